reservation_station: RTL
========================

Name: reservation_station

Overview:
- Single Tomasulo reservation station bound to one functional unit (FU), identified on the CDB by parameter RS_ID.
- Accepts a dispatched op and snoops the CDB for missing operands. Issues the op to its FU and holds the FU result.
- Presents fu_status/fu_result to the CDB arbiter until the arbiter's retiring_stations bit for this station is seen.
- Sits directly upstream of the CDB arbiter and downstream of dispatch; one instance per FU.

Parameters:
- DATA_WIDTH, 64, operand/result width.
- TAG_WIDTH, 3, width of CDB rs_id tags.
- OP_WIDTH, 4, opcode width forwarded to the FU.
- RS_ID, 0, this station's CDB tag; must be less than FUNCTIONAL_UNIT_COUNT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dispatch_valid  in  1  dispatch request.
- dispatch_ready  out  1  station can accept a dispatch this cycle.
- dispatch_op  in  OP_WIDTH  opcode.
- dispatch_vj, dispatch_vk  in  DATA_WIDTH  operand values, used when not pending.
- dispatch_qj_pending, dispatch_qk_pending  in  1  operand awaits a CDB tag.
- dispatch_qj, dispatch_qk  in  TAG_WIDTH  producer tag for a pending operand.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rs_id  in  TAG_WIDTH  broadcasting station tag.
- cdb_result  in  DATA_WIDTH  broadcast value.
- exec_valid  out  1  op and operands offered to FU.
- exec_ready  in  1  FU accepts.
- exec_op  out  OP_WIDTH;  exec_a, exec_b  out  DATA_WIDTH.
- exec_done  in  1  FU result valid, one-cycle pulse.
- exec_result  in  DATA_WIDTH  FU result.
- fu_status  out  1  result pending broadcast (to arbiter).
- fu_result  out  DATA_WIDTH  held result (to arbiter).
- retire  in  1  this station's bit of arbiter retiring_stations.
- busy  out  1  state != FREE.

Behaviour:
- Reset (async, rst_n=0):
  - State FREE.
  - All outputs 0 except dispatch_ready=1.
  - Operand slots cleared, pending=0.
  - Reset mid-operation discards the op with no broadcast.
- States: FREE, WAIT, ISSUE, EXEC, DONE. All outputs are registered or derived from state only.
- FREE:
  - dispatch_ready=1.
  - On dispatch_valid, latch op and both operand slots.
  - A pending operand whose tag equals cdb_rs_id while cdb_valid=1 in that same cycle captures cdb_result and is marked ready (dispatch-time forwarding, mandatory).
  - Next state is ISSUE if both operands are ready after forwarding, else WAIT.
- WAIT:
  - Each cycle, with cdb_valid=1, every pending slot with tag==cdb_rs_id captures cdb_result. Both slots may capture in the same cycle.
  - Go to ISSUE once no slot is pending. Readiness is evaluated on registered slot state, so the transition happens the cycle after the last capture.
- ISSUE:
  - exec_valid=1; exec_op/a/b are stable.
  - exec_valid&exec_ready goes to EXEC. Holding exec_valid while exec_ready=0 is required.
- EXEC:
  - exec_done latches exec_result into fu_result; go to DONE.
  - exec_done in any other state is ignored.
- DONE:
  - fu_status=1; fu_result held constant.
  - retire=1 clears fu_status and goes to FREE. fu_result may retain its value.
  - retire in any non-DONE state is ignored.
- Latency: with both operands ready at dispatch, exec_valid is high on the first cycle after dispatch. From DONE entry, fu_status is high on the first cycle.
- CDB broadcasts tagged RS_ID are ignored by own slots; a dispatch with pending tag==RS_ID is illegal (simulation assertion).
- Widths: captures are full DATA_WIDTH with no extension; tags are compared on all TAG_WIDTH bits.

Optional Feature:
- RS_RETIRE_REUSE_EN defined:
  - In DONE, dispatch_ready = retire, combinational from input.
  - Simultaneous retire and dispatch_valid frees the station and loads the new op in the same edge, with the FREE transition rules applied, including CDB forwarding.
- Undefined: dispatch_ready=1 only in FREE; a retired station accepts a dispatch no earlier than the following cycle.

Decomposition:
- Package cdb_pkg: DATA_WIDTH/TAG_WIDTH/OP_WIDTH defaults, rs_state_t enum, operand_slot_t struct (value, tag, pending).
- Sub-module rs_operand_slot, instantiated twice (j, k), owning:
  - load with dispatch-time forwarding;
  - CDB snoop/capture;
  - ready output.

Test Plan:
- Both operands ready: dispatch vj=5, vk=7, op=ADD → exec_valid next cycle with a=5, b=7; exec_done result=12 → fu_status=1, fu_result=12; retire → fu_status=0, dispatch_ready=1 next cycle.
- Pending qj=2: CDB rs_id=2, result=0xAB three cycles later → exec_a=0xAB; exec_valid asserts one cycle after capture; broadcast rs_id=3 ignored.
- Dispatch-cycle forwarding: dispatch qj=qk=4 pending while CDB rs_id=4, result=9 in the same cycle → exec_a=exec_b=9, exec_valid next cycle.
- Backpressure: exec_ready=0 for 4 cycles → exec_valid and operands held stable; fires on the cycle exec_ready=1.
- DONE held: retire=0 for 10 cycles → fu_status and fu_result unchanged; stray exec_done/retire in WAIT ignored; rst_n low in EXEC → all outputs 0 immediately, dispatch_ready=1.
- RS_RETIRE_REUSE_EN: retire and dispatch in the same cycle → new op in WAIT/ISSUE next cycle, fu_status=0; without the macro, dispatch_ready stays low in that cycle.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB/reservation-station types: default widths, station state, operand slot.
package cdb_pkg;

   localparam int DATA_WIDTH            = 64;
   localparam int TAG_WIDTH             = 3;
   localparam int OP_WIDTH              = 4;
   localparam int FUNCTIONAL_UNIT_COUNT = 8;

   typedef enum logic [2:0] {
      RS_FREE  = 3'd0,
      RS_WAIT  = 3'd1,
      RS_ISSUE = 3'd2,
      RS_EXEC  = 3'd3,
      RS_DONE  = 3'd4
   } rs_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] value;
      logic [TAG_WIDTH-1:0]  tag;
      logic                  pending;
   } operand_slot_t;

endpackage

// File: rtl/rs_operand_slot.sv
// One operand slot: loads at dispatch (with same-cycle CDB forwarding),
// then snoops the CDB until its producer tag is broadcast.
module rs_operand_slot
   import cdb_pkg::*;
#(
   parameter logic [TAG_WIDTH-1:0] RS_ID = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] d_value_i,
   input  logic                  d_pending_i,
   input  logic [TAG_WIDTH-1:0]  d_tag_i,
   input  logic                  cdb_valid_i,
   input  logic [TAG_WIDTH-1:0]  cdb_rs_id_i,
   input  logic [DATA_WIDTH-1:0] cdb_result_i,
   output logic [DATA_WIDTH-1:0] value_o,
   output logic                  ready_o,
   output logic                  load_ready_o
);

   operand_slot_t slot_q;
   logic          fwd_hit;
   logic          snoop_hit;

   // Our own broadcasts never feed our own slots, so RS_ID never matches.
   assign fwd_hit   = d_pending_i && cdb_valid_i && (cdb_rs_id_i == d_tag_i) && (d_tag_i != RS_ID);
   assign snoop_hit = slot_q.pending && cdb_valid_i && (cdb_rs_id_i == slot_q.tag) && (slot_q.tag != RS_ID);

   assign value_o      = slot_q.value;
   assign ready_o      = !slot_q.pending;
   assign load_ready_o = !d_pending_i || fwd_hit;

   // Slot register: dispatch load takes priority over snooping the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else if (load_i) begin
         slot_q.value   <= fwd_hit ? cdb_result_i : d_value_i;
         slot_q.tag     <= d_tag_i;
         slot_q.pending <= d_pending_i && !fwd_hit;
      end else if (snoop_hit) begin
         slot_q.value   <= cdb_result_i;
         slot_q.pending <= 1'b0;
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Single Tomasulo reservation station in front of one functional unit.
// Optional RS_RETIRE_REUSE_EN: a retiring station accepts a new dispatch in
// the same cycle. Widths follow cdb_pkg.
module reservation_station
   import cdb_pkg::*;
#(
   parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH,
   parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
   parameter int OP_WIDTH   = cdb_pkg::OP_WIDTH,
   parameter int RS_ID      = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dispatch_valid,
   output logic                  dispatch_ready,
   input  logic [OP_WIDTH-1:0]   dispatch_op,
   input  logic [DATA_WIDTH-1:0] dispatch_vj,
   input  logic [DATA_WIDTH-1:0] dispatch_vk,
   input  logic                  dispatch_qj_pending,
   input  logic                  dispatch_qk_pending,
   input  logic [TAG_WIDTH-1:0]  dispatch_qj,
   input  logic [TAG_WIDTH-1:0]  dispatch_qk,
   input  logic                  cdb_valid,
   input  logic [TAG_WIDTH-1:0]  cdb_rs_id,
   input  logic [DATA_WIDTH-1:0] cdb_result,
   output logic                  exec_valid,
   input  logic                  exec_ready,
   output logic [OP_WIDTH-1:0]   exec_op,
   output logic [DATA_WIDTH-1:0] exec_a,
   output logic [DATA_WIDTH-1:0] exec_b,
   input  logic                  exec_done,
   input  logic [DATA_WIDTH-1:0] exec_result,
   output logic                  fu_status,
   output logic [DATA_WIDTH-1:0] fu_result,
   input  logic                  retire,
   output logic                  busy
);

   localparam logic [TAG_WIDTH-1:0] RS_TAG = TAG_WIDTH'(RS_ID);

   rs_state_t             state_q;
   logic [OP_WIDTH-1:0]   op_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  accept;
   logic                  j_rdy, k_rdy, j_ld_rdy, k_ld_rdy;

`ifdef RS_RETIRE_REUSE_EN
   assign dispatch_ready = (state_q == RS_FREE) || ((state_q == RS_DONE) && retire);
`else
   assign dispatch_ready = (state_q == RS_FREE);
`endif
   assign accept     = dispatch_valid && dispatch_ready;
   assign exec_valid = (state_q == RS_ISSUE);
   assign exec_op    = op_q;
   assign fu_status  = (state_q == RS_DONE);
   assign fu_result  = result_q;
   assign busy       = (state_q != RS_FREE);

   rs_operand_slot #(.RS_ID(RS_TAG)) u_slot_j (
      .clk, .rst_n, .load_i(accept),
      .d_value_i(dispatch_vj), .d_pending_i(dispatch_qj_pending), .d_tag_i(dispatch_qj),
      .cdb_valid_i(cdb_valid), .cdb_rs_id_i(cdb_rs_id), .cdb_result_i(cdb_result),
      .value_o(exec_a), .ready_o(j_rdy), .load_ready_o(j_ld_rdy)
   );

   rs_operand_slot #(.RS_ID(RS_TAG)) u_slot_k (
      .clk, .rst_n, .load_i(accept),
      .d_value_i(dispatch_vk), .d_pending_i(dispatch_qk_pending), .d_tag_i(dispatch_qk),
      .cdb_valid_i(cdb_valid), .cdb_rs_id_i(cdb_rs_id), .cdb_result_i(cdb_result),
      .value_o(exec_b), .ready_o(k_rdy), .load_ready_o(k_ld_rdy)
   );

   // Station FSM; an accepted dispatch (from FREE, or DONE+retire when reuse is on) wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RS_FREE;
         op_q     <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q    <= dispatch_op;
         state_q <= (j_ld_rdy && k_ld_rdy) ? RS_ISSUE : RS_WAIT;
      end else begin
         case (state_q)
            RS_WAIT:  if (j_rdy && k_rdy) state_q <= RS_ISSUE;
            RS_ISSUE: if (exec_ready) state_q <= RS_EXEC;
            RS_EXEC:  if (exec_done) begin
                         result_q <= exec_result;
                         state_q  <= RS_DONE;
                      end
            RS_DONE:  if (retire) state_q <= RS_FREE;
            default:  ;
         endcase
      end
   end

`ifndef SYNTHESIS
   // A slot waiting on this station's own tag could never be woken up.
   always_ff @(posedge clk) begin
      if (rst_n && accept) begin
         assert (!(dispatch_qj_pending && dispatch_qj == RS_TAG) &&
                 !(dispatch_qk_pending && dispatch_qk == RS_TAG))
            else $error("reservation_station: dispatch pending on own tag");
      end
   end
`endif

endmodule
